bwm_mac_acc: RTL and testbench

BWM_MAC_ACC -- requirements
Module: bwm_mac_acc

---
 rtl/bwm_mac_acc.sv | 120 ++++++++++++
 tb/tb_bwm_mac_acc.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bwm_mac_acc.sv
// bwm_mac_acc: accumulates signed 8-bit Baugh-Wooley products into an ACC_W-bit dot-product sum.
// Optional feature: define BWM_MAC_SAT_EN to saturate (instead of wrap) on signed overflow.
module bwm_mac_acc #(
    parameter int ACC_W = 12,
    parameter int LEN   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_p,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [3:0]       out_count,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid-side data must stay stable until that edge, and ready never depends on valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [3:0]       LEN_4   = 4'(LEN);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             acc_ovf;
    logic [3:0]       count;

    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] raw_sum;
    logic [ACC_W-1:0] new_sum;
    logic [3:0]       count_next;
    logic             add_ovf;
    logic             ovf_next;
    logic             accept;
    logic             is_final;
    logic             take;

    // A beat taken in IDLE starts a fresh dot product, so the old sum/flag are ignored.
    always_comb begin
        p_ext      = ACC_W'($signed(in_p));
        base       = (state == IDLE) ? '0 : acc;
        raw_sum    = base + p_ext;
        add_ovf    = (base[ACC_W-1] == p_ext[ACC_W-1]) && (raw_sum[ACC_W-1] != base[ACC_W-1]);
        new_sum    = raw_sum;
`ifdef BWM_MAC_SAT_EN
        if (add_ovf) begin
            new_sum = p_ext[ACC_W-1] ? SUM_MIN : SUM_MAX;
        end
`endif
        ovf_next   = ((state == IDLE) ? 1'b0 : acc_ovf) | add_ovf;
        count_next = ((state == IDLE) ? 4'd0 : count) + 4'd1;
        accept     = in_valid && in_ready;
        is_final   = in_last || (count_next == LEN_4);
        take       = out_valid && out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            acc_ovf   <= 1'b0;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        acc     <= new_sum;
                        count   <= count_next;
                        acc_ovf <= ovf_next;
                        if (is_final) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_sum   <= new_sum;
                            out_count <= count_next;
                            ovf       <= ovf_next;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // in_ready stays low through the consume cycle: one bubble before the next beat.
                    if (take) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        count     <= '0;
                        acc_ovf   <= 1'b0;
                        ovf       <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_bwm_mac_acc.sv
// Bench for bwm_mac_acc: three instances (12b/LEN4, 8b/LEN4, 12b/LEN1) with directed cases and random traffic.
module tb_bwm_mac_acc;

    logic       clk;
    logic       rst_n;
    logic       in_valid  [3];
    logic       in_last   [3];
    logic       out_ready [3];
    logic [7:0] in_p      [3];
    logic       in_ready  [3];
    logic       out_valid [3];
    logic       ovf       [3];
    logic [3:0] out_count [3];
    logic [1:0] dbg_state [3];
    logic [11:0] sum0;
    logic [7:0]  sum1;
    logic [11:0] sum2;

    int n_cmp = 0;
    int n_err = 0;
    int edges = 0;
    bit mon_en = 1'b0;
    bit rand_on = 1'b0;

    bwm_mac_acc #(.ACC_W(12), .LEN(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_p(in_p[0]), .in_last(in_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(sum0), .out_count(out_count[0]), .ovf(ovf[0]), .dbg_state(dbg_state[0])
    );
    bwm_mac_acc #(.ACC_W(8), .LEN(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_p(in_p[1]), .in_last(in_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(sum1), .out_count(out_count[1]), .ovf(ovf[1]), .dbg_state(dbg_state[1])
    );
    bwm_mac_acc #(.ACC_W(12), .LEN(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_p(in_p[2]), .in_last(in_last[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum(sum2), .out_count(out_count[2]), .ovf(ovf[2]), .dbg_state(dbg_state[2])
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check_eq(string tag, int got, int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int len_of(int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic int accw_of(int i);
        return (i == 1) ? 8 : 12;
    endfunction

    function automatic int get_sum(int i);
        case (i)
            0:       return int'($signed(sum0));
            1:       return int'($signed(sum1));
            default: return int'($signed(sum2));
        endcase
    endfunction

    // ---------------- reference model + scoreboard ----------------
    // Entry packing: {ovf, count[3:0], sum[15:0]}
    logic [20:0] exp_q0[$];
    logic [20:0] exp_q1[$];
    logic [20:0] exp_q2[$];
    bit m_hold [3];
    int m_acc  [3];
    int m_cnt  [3];
    bit m_ovf  [3];

    function automatic void q_push(int i, logic [20:0] v);
        case (i)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endfunction

    function automatic logic [20:0] q_pop(int i);
        case (i)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    function automatic logic [20:0] q_front(int i);
        case (i)
            0:       return exp_q0[0];
            1:       return exp_q1[0];
            default: return exp_q2[0];
        endcase
    endfunction

    function automatic int q_size(int i);
        case (i)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic void model_add(int i, int p);
        int w;
        int mx;
        int mn;
        int s;
        w  = accw_of(i);
        mx = (1 << (w - 1)) - 1;
        mn = -(1 << (w - 1));
        if (m_cnt[i] == 0) begin
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
        end
        s = m_acc[i] + p;
        if (s > mx || s < mn) begin
            m_ovf[i] = 1'b1;
`ifdef BWM_MAC_SAT_EN
            s = (s > mx) ? mx : mn;
`else
            s = (s > mx) ? s - (1 << w) : s + (1 << w);
`endif
        end
        m_acc[i] = s;
        m_cnt[i] = m_cnt[i] + 1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
            exp_q2.delete();
            for (int i = 0; i < 3; i++) begin
                m_hold[i] = 1'b0;
                m_acc[i]  = 0;
                m_cnt[i]  = 0;
                m_ovf[i]  = 1'b0;
                if (mon_en) begin
                    check_eq($sformatf("i%0d_rst_valid", i), int'(out_valid[i]), 0);
                    check_eq($sformatf("i%0d_rst_ready", i), int'(in_ready[i]), 0);
                    check_eq($sformatf("i%0d_rst_sum", i), get_sum(i), 0);
                    check_eq($sformatf("i%0d_rst_count", i), int'(out_count[i]), 0);
                    check_eq($sformatf("i%0d_rst_ovf", i), int'(ovf[i]), 0);
                end
            end
        end else if (mon_en && edges > 0) begin
            for (int i = 0; i < 3; i++) begin
                logic [20:0] e;
                check_eq($sformatf("i%0d_valid", i), int'(out_valid[i]), int'(m_hold[i]));
                check_eq($sformatf("i%0d_ready", i), int'(in_ready[i]), int'(!m_hold[i]));
                if (m_hold[i]) begin
                    e = q_front(i);
                    check_eq($sformatf("i%0d_sum", i), get_sum(i), int'($signed(e[15:0])));
                    check_eq($sformatf("i%0d_count", i), int'(out_count[i]), int'(e[19:16]));
                    check_eq($sformatf("i%0d_ovf", i), int'(ovf[i]), int'(e[20]));
                    if (out_ready[i]) begin
                        e = q_pop(i);
                        m_hold[i] = 1'b0;
                        m_cnt[i]  = 0;
                    end
                end else if (in_valid[i]) begin
                    model_add(i, int'($signed(in_p[i])));
                    if (in_last[i] || m_cnt[i] == len_of(i)) begin
                        q_push(i, {m_ovf[i], 4'(m_cnt[i]), 16'(m_acc[i])});
                        m_hold[i] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change only at posedge+1; sampling happens on negedge.
    task automatic send_beat(int i, int p, bit last);
        int t;
        t = 0;
        in_valid[i] = 1'b1;
        in_p[i]     = 8'(p);
        in_last[i]  = last;
        @(negedge clk);
        while (!in_ready[i] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq($sformatf("i%0d_ready_wait", i), int'(in_ready[i]), 1);
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
    endtask

    task automatic expect_result(string tag, int i, int sum, int cnt, int ov, int hold);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_valid"}, int'(out_valid[i]), 1);
        check_eq({tag, "_sum"}, get_sum(i), sum);
        check_eq({tag, "_count"}, int'(out_count[i]), cnt);
        check_eq({tag, "_ovf"}, int'(ovf[i]), ov);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, int'(out_valid[i]), 1);
            check_eq({tag, "_hold_ready"}, int'(in_ready[i]), 0);
            check_eq({tag, "_hold_sum"}, get_sum(i), sum);
            check_eq({tag, "_hold_count"}, int'(out_count[i]), cnt);
        end
        @(posedge clk);
        #1;
        out_ready[i] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[i] = 1'b0;
    endtask

    task automatic idle_cycles(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_stream(int i, int n_dots);
        for (int d = 0; d < n_dots; d++) begin
            int len;
            len = $urandom_range(1, len_of(i));
            for (int b = 0; b < len; b++) begin
                int p;
                bit last;
                if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
                if ($urandom_range(0, 3) == 0)
                    p = ($urandom_range(0, 1) == 1) ? 127 : -128;
                else
                    p = int'($urandom_range(0, 255)) - 128;
                if (b == len - 1) last = (len < len_of(i)) ? 1'b1 : 1'($urandom_range(0, 1));
                else              last = 1'b0;
                send_beat(i, p, last);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_on) begin
                for (int i = 0; i < 3; i++) out_ready[i] = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_last[i]   = 1'b0;
            in_p[i]      = 8'd0;
            out_ready[i] = 1'b0;
        end
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(2);

        // Four beats, final by count
        send_beat(0, 64, 1'b0);
        send_beat(0, -56, 1'b0);
        send_beat(0, 7, 1'b0);
        send_beat(0, -1, 1'b0);
        expect_result("len4", 0, 14, 4, 0, 0);

        // Early in_last with backpressure
        send_beat(0, 20, 1'b0);
        send_beat(0, 5, 1'b1);
        expect_result("last2", 0, 25, 2, 0, 3);

        // Signed overflow in an 8-bit accumulator
        send_beat(1, 64, 1'b0);
        send_beat(1, 64, 1'b1);
`ifdef BWM_MAC_SAT_EN
        expect_result("ovf8", 1, 127, 2, 1, 1);
`else
        expect_result("ovf8", 1, -128, 2, 1, 1);
`endif

        // LEN=1: every beat is final
        send_beat(2, -8, 1'b0);
        expect_result("len1", 2, -8, 1, 0, 0);

        // Back-to-back with out_ready tied high
        out_ready[0] = 1'b1;
        send_beat(0, 3, 1'b0);
        send_beat(0, 4, 1'b1);
        @(negedge clk);
        check_eq("b2b_first_valid", int'(out_valid[0]), 1);
        check_eq("b2b_first_bubble", int'(in_ready[0]), 0);
        check_eq("b2b_first_sum", get_sum(0), 7);
        @(posedge clk);
        #1;
        send_beat(0, 10, 1'b0);
        send_beat(0, -2, 1'b1);
        @(negedge clk);
        check_eq("b2b_second_sum", get_sum(0), 8);
        check_eq("b2b_second_count", int'(out_count[0]), 2);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        idle_cycles(2);

        // Reset mid-dot-product and while another instance holds a result
        send_beat(1, 3, 1'b0);
        send_beat(1, 4, 1'b1);
        send_beat(0, 1, 1'b0);
        send_beat(0, 1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("i%0d_async_valid", i), int'(out_valid[i]), 0);
            check_eq($sformatf("i%0d_async_ready", i), int'(in_ready[i]), 0);
            check_eq($sformatf("i%0d_async_sum", i), get_sum(i), 0);
            check_eq($sformatf("i%0d_async_count", i), int'(out_count[i]), 0);
            check_eq($sformatf("i%0d_async_ovf", i), int'(ovf[i]), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int b = 0; b < 4; b++) send_beat(0, 1, 1'b0);
        expect_result("post_rst", 0, 4, 4, 0, 0);

        // Random traffic on all three instances in parallel
        rand_on = 1'b1;
        fork
            rand_stream(0, 60);
            rand_stream(1, 60);
            rand_stream(2, 60);
        join
        rand_on = 1'b0;
        idle_cycles(1);
        for (int i = 0; i < 3; i++) out_ready[i] = 1'b1;
        idle_cycles(6);
        for (int i = 0; i < 3; i++) begin
            out_ready[i] = 1'b0;
            check_eq($sformatf("i%0d_drain", i), q_size(i), 0);
        end
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
